// File: rtl/pcs_rx_block_lock.sv
// pcs_rx_block_lock: 10GBASE-R receive block-lock FSM driving SERDES bitslip and reset request.
// Define BLOCK_LOCK_STATS_EN to add saturating slip and lock-loss statistics ports.
module pcs_rx_block_lock #(
   parameter int HDR_WIDTH           = 2,
   parameter int SH_CNT_MAX          = 64,
   parameter int SH_INVALID_MAX      = 16,
   parameter int BITSLIP_HIGH_CYCLES = 1,
   parameter int BITSLIP_LOW_CYCLES  = 8,
   parameter int SLIP_RESET_COUNT    = 66
) (
   input  logic                 rx_clk,
   input  logic                 rx_rst_n,
   input  logic [HDR_WIDTH-1:0] serdes_rx_hdr,
   input  logic                 serdes_rx_hdr_valid,
   output logic                 serdes_rx_bitslip,
   output logic                 serdes_rx_reset_req,
   output logic                 rx_block_lock,
   output logic                 rx_sh_invalid
`ifdef BLOCK_LOCK_STATS_EN
   ,
   output logic [15:0]          rx_slip_count,
   output logic [15:0]          rx_lock_loss_count
`else
`endif
);
   localparam int TMR_W = $clog2(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_HI = TMR_W'(BITSLIP_HIGH_CYCLES);
   localparam logic [6:0] SH_MAX = 7'(SH_CNT_MAX);
   localparam logic [4:0] INV_MAX = 5'(SH_INVALID_MAX);
   localparam logic [6:0] RUN_MAX = 7'(SLIP_RESET_COUNT);
   typedef enum logic [1:0] {UNLOCKED, LOCKED, SLIP} state_t;
   state_t state_q, state_d;
   logic [6:0] sh_cnt_q, sh_cnt_d, run_q, run_d;
   logic [4:0] inv_q, inv_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic bitslip_q, bitslip_d, req_q, req_d, lock_q, lock_d, shinv_q, shinv_d;
   logic sample, bad, enter;
   always_comb begin
      state_d  = state_q;
      sh_cnt_d = sh_cnt_q;
      inv_d    = inv_q;
      tmr_d    = tmr_q;
      run_d    = run_q;
      req_d    = 1'b0;
      sample   = serdes_rx_hdr_valid && state_q != SLIP;
      bad      = ~^serdes_rx_hdr;
      shinv_d  = sample && bad;
      case (state_q)
         UNLOCKED: if (sample) begin
            if (bad) state_d = SLIP;
            else begin
               sh_cnt_d = sh_cnt_q + 7'd1;
               if (sh_cnt_d == SH_MAX) begin
                  state_d  = LOCKED;
                  sh_cnt_d = '0;
                  run_d    = '0;
               end
            end
         end
         LOCKED: if (sample) begin
            sh_cnt_d = sh_cnt_q + 7'd1;
            inv_d    = inv_q + {4'd0, bad};
            // losing lock takes priority over a window boundary on the same header
            if (inv_d == INV_MAX) state_d = SLIP;
            else if (sh_cnt_d == SH_MAX) begin
               sh_cnt_d = '0;
               inv_d    = '0;
            end
         end
         SLIP: if (tmr_q == TMR_LAST) state_d = UNLOCKED;
               else tmr_d = tmr_q + 1'b1;
         default: state_d = UNLOCKED;
      endcase
      enter = state_d == SLIP && state_q != SLIP;
      if (enter) begin
         sh_cnt_d = '0;
         inv_d    = '0;
         tmr_d    = '0;
         run_d    = run_q + 7'd1;
         if (run_d == RUN_MAX) begin
            run_d = '0;
            req_d = 1'b1;
         end
      end
      bitslip_d = state_d == SLIP && tmr_d < TMR_HI;
      lock_d    = state_d == LOCKED;
   end
   always_ff @(posedge rx_clk) begin
      if (!rx_rst_n) begin
         state_q   <= UNLOCKED;
         sh_cnt_q  <= '0;
         inv_q     <= '0;
         tmr_q     <= '0;
         run_q     <= '0;
         bitslip_q <= 1'b0;
         req_q     <= 1'b0;
         lock_q    <= 1'b0;
         shinv_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_cnt_q  <= sh_cnt_d;
         inv_q     <= inv_d;
         tmr_q     <= tmr_d;
         run_q     <= run_d;
         bitslip_q <= bitslip_d;
         req_q     <= req_d;
         lock_q    <= lock_d;
         shinv_q   <= shinv_d;
      end
   end
   assign serdes_rx_bitslip   = bitslip_q;
   assign serdes_rx_reset_req = req_q;
   assign rx_block_lock       = lock_q;
   assign rx_sh_invalid       = shinv_q;
`ifdef BLOCK_LOCK_STATS_EN
   logic [15:0] slip_cnt_q, loss_cnt_q;
   always_ff @(posedge rx_clk) begin
      if (!rx_rst_n) begin
         slip_cnt_q <= '0;
         loss_cnt_q <= '0;
      end else begin
         if (enter && slip_cnt_q != 16'hFFFF) slip_cnt_q <= slip_cnt_q + 16'd1;
         if (enter && state_q == LOCKED && loss_cnt_q != 16'hFFFF) loss_cnt_q <= loss_cnt_q + 16'd1;
      end
   end
   assign rx_slip_count      = slip_cnt_q;
   assign rx_lock_loss_count = loss_cnt_q;
`else
`endif
endmodule

// File: tb/tb_pcs_rx_block_lock.sv
// tb_pcs_rx_block_lock: directed checks of lock acquisition, retention, loss, slip timing and reset request.
module tb_pcs_rx_block_lock;
   logic       rx_clk = 1'b0;
   logic       rx_rst_n = 1'b0;
   logic [1:0] serdes_rx_hdr = 2'b01;
   logic       serdes_rx_hdr_valid = 1'b0;
   logic       serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_sh_invalid;
`ifdef BLOCK_LOCK_STATS_EN
   logic [15:0] rx_slip_count, rx_lock_loss_count;
`endif
   int errors = 0, checks = 0;
   always #5 rx_clk = ~rx_clk;
   pcs_rx_block_lock dut (
      .rx_clk              (rx_clk),
      .rx_rst_n            (rx_rst_n),
      .serdes_rx_hdr       (serdes_rx_hdr),
      .serdes_rx_hdr_valid (serdes_rx_hdr_valid),
      .serdes_rx_bitslip   (serdes_rx_bitslip),
      .serdes_rx_reset_req (serdes_rx_reset_req),
      .rx_block_lock       (rx_block_lock),
`ifdef BLOCK_LOCK_STATS_EN
      .rx_slip_count       (rx_slip_count),
      .rx_lock_loss_count  (rx_lock_loss_count),
`endif
      .rx_sh_invalid       (rx_sh_invalid)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // inputs change on the falling edge; outputs are read one full cycle later
   task automatic cyc(input logic [1:0] h, input logic v);
      serdes_rx_hdr = h;
      serdes_rx_hdr_valid = v;
      @(negedge rx_clk);
   endtask
   initial begin
      int n, slips, reqs, t1, t2, locks;
      logic prev;
      logic [1:0] h;
      logic v;
      cyc(2'b01, 1'b0);
      cyc(2'b00, 1'b1);
      check("rst_bitslip", serdes_rx_bitslip, 0);
      check("rst_req", serdes_rx_reset_req, 0);
      check("rst_lock", rx_block_lock, 0);
      check("rst_shinv", rx_sh_invalid, 0);
`ifdef BLOCK_LOCK_STATS_EN
      check("rst_slipcnt", rx_slip_count, 0);
      check("rst_losscnt", rx_lock_loss_count, 0);
`endif
      rx_rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 63; i++) begin
         cyc(i[0] ? 2'b10 : 2'b01, 1'b1);
         n += int'(rx_block_lock | serdes_rx_bitslip | rx_sh_invalid);
      end
      check("acq_early", n, 0);
      cyc(2'b10, 1'b1);
      check("acq_lock", rx_block_lock, 1);
      check("acq_noslip", serdes_rx_bitslip, 0);
      n = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(i[0] ? 2'b11 : 2'b00, 1'b1);
         n += int'(!rx_block_lock);
         if (i == 0) check("ret_shinv", rx_sh_invalid, 1);
      end
      for (int i = 0; i < 49; i++) begin
         cyc(2'b01, 1'b1);
         n += int'(!rx_block_lock | serdes_rx_bitslip);
      end
      check("ret_hold", n, 0);
      n = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(2'b00, 1'b1);
         n += int'(!rx_block_lock);
      end
      check("ret_fresh", n, 0);
      cyc(2'b11, 1'b1);
      check("loss_lock", rx_block_lock, 0);
      check("loss_bitslip", serdes_rx_bitslip, 1);
      check("loss_shinv", rx_sh_invalid, 1);
`ifdef BLOCK_LOCK_STATS_EN
      check("loss_cnt1", rx_lock_loss_count, 1);
`endif
      n = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(2'b00, 1'b1);
         n += int'(rx_sh_invalid | serdes_rx_bitslip | rx_block_lock);
      end
      check("slip_ignored", n, 0);
      cyc(2'b00, 1'b1);
      check("slip_end_shinv", rx_sh_invalid, 1);
      check("slip_end_bitslip", serdes_rx_bitslip, 1);
      for (int i = 0; i < 9; i++) cyc(2'b01, 1'b1);
      for (int i = 0; i < 10; i++) cyc(2'b10, 1'b1);
      cyc(2'b00, 1'b1);
      check("uslip_bitslip", serdes_rx_bitslip, 1);
      n = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(2'b00, 1'b1);
         n += int'(rx_sh_invalid | serdes_rx_bitslip);
      end
      check("uslip_ignored", n, 0);
      n = 0;
      for (int i = 0; i < 63; i++) begin
         cyc(i[0] ? 2'b01 : 2'b10, 1'b1);
         n += int'(rx_block_lock);
      end
      check("relock_early", n, 0);
      cyc(2'b01, 1'b1);
      check("relock", rx_block_lock, 1);
      n = 0;
      for (int i = 0; i < 48; i++) begin
         cyc(2'b10, 1'b1);
         n += int'(!rx_block_lock);
      end
      for (int i = 0; i < 15; i++) begin
         cyc(2'b11, 1'b1);
         n += int'(!rx_block_lock);
      end
      check("edge_hold", n, 0);
      cyc(2'b00, 1'b1);
      check("edge_slip_wins", rx_block_lock, 0);
      check("edge_bitslip", serdes_rx_bitslip, 1);
`ifdef BLOCK_LOCK_STATS_EN
      check("loss_cnt2", rx_lock_loss_count, 2);
`endif
      rx_rst_n = 1'b0;
      cyc(2'b00, 1'b1);
      check("midslip_rst_bitslip", serdes_rx_bitslip, 0);
      rx_rst_n = 1'b1;
      cyc(2'b00, 1'b1);
      check("post_rst_sample", rx_sh_invalid, 1);
      rx_rst_n = 1'b0;
      cyc(2'b01, 1'b0);
      rx_rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 128; i++) begin
         v = !i[0];
         cyc(v ? (i[1] ? 2'b10 : 2'b01) : 2'b11, v);
         if (i < 126) n += int'(rx_block_lock | rx_sh_invalid);
         if (i == 126) check("gap_lock", rx_block_lock, 1);
      end
      check("gap_early", n, 0);
      rx_rst_n = 1'b0;
      cyc(2'b01, 1'b1);
      check("rst_clears_lock", rx_block_lock, 0);
      rx_rst_n = 1'b1;
      slips = 0; reqs = 0; t1 = 0; t2 = 0; locks = 0; prev = 1'b0;
      for (int c = 0; c < 1400; c++) begin
         h = ((c / 5) % 2 != 0) ? 2'b11 : 2'b00;
         cyc(h, 1'b1);
         if (serdes_rx_bitslip && !prev) begin
            slips++;
            if (slips == 1) t1 = c;
            if (slips == 2) t2 = c;
         end
         if (serdes_rx_reset_req) begin
            reqs++;
            check("req_with_slip", serdes_rx_bitslip, 1);
            check("req_slip_index", slips, reqs * 66);
`ifdef BLOCK_LOCK_STATS_EN
            if (reqs == 1) check("req_slipcnt", rx_slip_count, 66);
`endif
         end
         locks += int'(rx_block_lock);
         prev = serdes_rx_bitslip;
      end
      check("bad_slips", slips, 140);
      check("bad_period", t2 - t1, 10);
      check("bad_reqs", reqs, 2);
      check("bad_nolock", locks, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
